m_mem_responder: RTL and testbench



---
 rtl/m_mem_responder.sv | 258 +++++++++++++++++++++++++
 tb/tb_m_mem_responder.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/m_mem_responder.sv
// m_mem_responder
//   Fixed-latency, BRAM-backed memory responder for the single-word
//   rd_en/wr_en/busy handshake. It stands in for the SDRAM backend in
//   simulation and on small FPGA builds. After reset it holds o_busy high
//   for INIT_CYCLES cycles. Each access then holds o_busy high for exactly
//   LATENCY cycles, and the read/write is committed on the edge where busy
//   falls. Writes are masked per byte lane.
//
//   Optional feature (macro MEM_REFRESH_STALL_EN): periodic refresh windows
//   that stall the bus for REFRESH_CYCLES every REFRESH_PERIOD cycles.
//
// Ports
//   clk          system clock
//   rst          synchronous, active-high reset
//   i_rd_en      read request
//   i_wr_en      write request (ignored when i_rd_en is also high)
//   i_addr       byte address; only bits [ADDR_WIDTH-1:2] are decoded
//   i_data       write data
//   i_ctrl       write byte enables, bit n -> byte lane n
//   o_data       registered read data, stable until the next read completes
//   o_busy       responder busy
//   o_init_done  sticky flag, set once the post-reset stall is over
module m_mem_responder #(
    parameter int ADDR_WIDTH     = 16,
    parameter int LATENCY        = 4,
    parameter int INIT_CYCLES    = 8,
    parameter     PRELOAD_FILE   = "",
    parameter int REFRESH_PERIOD = 64,
    parameter int REFRESH_CYCLES = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_rd_en,
    input  logic        i_wr_en,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_data,
    input  logic [3:0]  i_ctrl,
    output logic [31:0] o_data,
    output logic        o_busy,
    output logic        o_init_done
);

    localparam int WORD_W = ADDR_WIDTH - 2;
    localparam int DEPTH  = 1 << WORD_W;
    localparam logic [7:0] INIT_LAST = 8'(INIT_CYCLES - 1);
    localparam logic [7:0] LAT_LAST  = 8'(LATENCY - 1);

    typedef enum logic [1:0] {
        ST_INIT   = 2'd0,
        ST_IDLE   = 2'd1,
        ST_ACCESS = 2'd2
`ifdef MEM_REFRESH_STALL_EN
        ,
        ST_REFRESH = 2'd3
`endif
    } state_t;

    state_t              state_q, state_d;
    logic [7:0]          cnt_q, cnt_d;
    logic                busy_q, busy_d;
    logic                init_done_q, init_done_d;
    logic                pend_q, pend_d;
    logic                pend_rd_q, pend_rd_d;
    logic [WORD_W-1:0]   pend_addr_q, pend_addr_d;
    logic [31:0]         pend_data_q, pend_data_d;
    logic [3:0]          pend_ctrl_q, pend_ctrl_d;
    logic [31:0]         data_q;
    logic                req_any;
    logic                rd_fire, wr_fire;
    logic                unused_addr_bits;

    logic [31:0] mem [0:DEPTH-1];

    // Power-up image for the BRAM: all zero.
    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = 32'h0;
    end

    assign req_any          = i_rd_en | i_wr_en;
    assign unused_addr_bits = ^{i_addr[31:ADDR_WIDTH], i_addr[1:0]};

    // The commit happens on the same edge that drops busy.
    assign rd_fire = (state_q == ST_ACCESS) && (cnt_q == LAT_LAST) && pend_rd_q;
    assign wr_fire = (state_q == ST_ACCESS) && (cnt_q == LAT_LAST) && !pend_rd_q;

`ifdef MEM_REFRESH_STALL_EN
    localparam int RCW = $clog2(REFRESH_PERIOD + 1);
    localparam logic [RCW-1:0] REF_LAST  = RCW'(REFRESH_PERIOD - 1);
    localparam logic [7:0]     RWIN_LAST = 8'(REFRESH_CYCLES - 1);

    logic [RCW-1:0] ref_cnt_q, ref_cnt_d;
    logic           ref_due_q, ref_due_d;
    // Set when an access finished while a refresh was owed, so that refresh
    // wins over a new request in the following IDLE cycle.
    logic           ref_after_q, ref_after_d;
`else
    localparam int unused_refresh_cfg = REFRESH_PERIOD + REFRESH_CYCLES;
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        busy_d      = busy_q;
        init_done_d = init_done_q;
        pend_d      = pend_q;
        pend_rd_d   = pend_rd_q;
        pend_addr_d = pend_addr_q;
        pend_data_d = pend_data_q;
        pend_ctrl_d = pend_ctrl_q;
`ifdef MEM_REFRESH_STALL_EN
        ref_cnt_d   = ref_cnt_q;
        ref_due_d   = ref_due_q;
        ref_after_d = ref_after_q;
`endif

        // One-deep request slot. In IDLE this same capture feeds the access
        // that starts on this edge.
        if (state_q != ST_ACCESS && !pend_q && req_any) begin
            pend_d      = 1'b1;
            pend_rd_d   = i_rd_en;
            pend_addr_d = i_addr[ADDR_WIDTH-1:2];
            pend_data_d = i_data;
            pend_ctrl_d = i_ctrl;
        end

        case (state_q)
            ST_INIT: begin
                if (cnt_q == INIT_LAST) begin
                    state_d     = ST_IDLE;
                    cnt_d       = 8'd0;
                    busy_d      = 1'b0;
                    init_done_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_IDLE: begin
`ifdef MEM_REFRESH_STALL_EN
                if (ref_due_q && (!(pend_q || req_any) || ref_after_q)) begin
                    state_d     = ST_REFRESH;
                    cnt_d       = 8'd0;
                    busy_d      = 1'b1;
                    ref_after_d = 1'b0;
                end else
`endif
                if (pend_q || req_any) begin
                    state_d = ST_ACCESS;
                    cnt_d   = 8'd0;
                    busy_d  = 1'b1;
                end
            end
            ST_ACCESS: begin
                if (cnt_q == LAT_LAST) begin
                    state_d = ST_IDLE;
                    cnt_d   = 8'd0;
                    busy_d  = 1'b0;
                    pend_d  = 1'b0;
`ifdef MEM_REFRESH_STALL_EN
                    ref_after_d = ref_due_q;
`endif
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
`ifdef MEM_REFRESH_STALL_EN
            ST_REFRESH: begin
                if (cnt_q == RWIN_LAST) begin
                    ref_due_d = 1'b0;
                    cnt_d     = 8'd0;
                    // A request parked during refresh starts immediately, so
                    // busy stays high straight into the access.
                    if (pend_q) begin
                        state_d = ST_ACCESS;
                    end else begin
                        state_d = ST_IDLE;
                        busy_d  = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
`endif
            default: begin
                state_d = ST_INIT;
                cnt_d   = 8'd0;
                busy_d  = 1'b1;
            end
        endcase

`ifdef MEM_REFRESH_STALL_EN
        // Free-running after init; a new due event overrides the clear above.
        if (state_q != ST_INIT) begin
            if (ref_cnt_q == REF_LAST) begin
                ref_cnt_d = '0;
                ref_due_d = 1'b1;
            end else begin
                ref_cnt_d = ref_cnt_q + 1'b1;
            end
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_INIT;
            cnt_q       <= 8'd0;
            busy_q      <= 1'b1;
            init_done_q <= 1'b0;
            pend_q      <= 1'b0;
`ifdef MEM_REFRESH_STALL_EN
            ref_cnt_q   <= '0;
            ref_due_q   <= 1'b0;
            ref_after_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            busy_q      <= busy_d;
            init_done_q <= init_done_d;
            pend_q      <= pend_d;
`ifdef MEM_REFRESH_STALL_EN
            ref_cnt_q   <= ref_cnt_d;
            ref_due_q   <= ref_due_d;
            ref_after_q <= ref_after_d;
`endif
        end
    end

    // Request payload: only meaningful while pend_q is set, so no reset.
    always_ff @(posedge clk) begin
        pend_rd_q   <= pend_rd_d;
        pend_addr_q <= pend_addr_d;
        pend_data_q <= pend_data_d;
        pend_ctrl_q <= pend_ctrl_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q <= 32'h0;
        end else if (rd_fire) begin
            data_q <= mem[pend_addr_q];
        end
    end

    // Reset during an access abandons it, so the write is gated by rst.
    always_ff @(posedge clk) begin
        if (!rst && wr_fire) begin
            for (int b = 0; b < 4; b++) begin
                if (pend_ctrl_q[b]) mem[pend_addr_q][8*b +: 8] <= pend_data_q[8*b +: 8];
            end
        end
    end

    assign o_data      = data_q;
    assign o_busy      = busy_q;
    assign o_init_done = init_done_q;

endmodule

// File: tb/tb_m_mem_responder.sv
module tb_m_mem_responder;

    localparam int LAT   = 4;
    localparam int INITC = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        rd, wr;
    logic [31:0] addr, wdata;
    logic [3:0]  ctrl;
    logic [31:0] o_data;
    logic        o_busy, o_init_done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    m_mem_responder #(
        .ADDR_WIDTH(16), .LATENCY(LAT), .INIT_CYCLES(INITC), .PRELOAD_FILE(""),
        .REFRESH_PERIOD(64), .REFRESH_CYCLES(6)
    ) dut (
        .clk(clk), .rst(rst), .i_rd_en(rd), .i_wr_en(wr), .i_addr(addr),
        .i_data(wdata), .i_ctrl(ctrl), .o_data(o_data), .o_busy(o_busy),
        .o_init_done(o_init_done)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Behavioural model: busy is a countdown of remaining stall cycles, the
    // memory is a sparse word map, and a request is one optional slot.
    bit          m_valid = 0;
    bit          cmp_en  = 0;
    bit          m_busy, m_done, m_serving, m_pend, m_prd;
    int          m_left;
    logic [31:0] m_data, m_pdata;
    logic [13:0] m_pword;
    logic [3:0]  m_pctrl;
    logic [31:0] m_mem [int];

    function automatic logic [31:0] m_read(input int k);
        return m_mem.exists(k) ? m_mem[k] : 32'h0;
    endfunction

    task automatic model_step();
        logic [31:0] w;
        if (rst) begin
            m_valid = 1; m_busy = 1; m_done = 0; m_data = 32'h0;
            m_pend = 0; m_serving = 0; m_left = INITC;
        end else if (m_valid) begin
            if (!m_serving && !m_pend && (rd || wr)) begin
                m_pend = 1; m_prd = rd; m_pword = addr[15:2]; m_pdata = wdata; m_pctrl = ctrl;
            end
            if (!m_done) begin
                m_left--;
                if (m_left == 0) begin m_busy = 0; m_done = 1; end
            end else if (m_serving) begin
                m_left--;
                if (m_left == 0) begin
                    if (m_prd) m_data = m_read(int'(m_pword));
                    else begin
                        w = m_read(int'(m_pword));
                        for (int b = 0; b < 4; b++)
                            if (m_pctrl[b]) w[8*b +: 8] = m_pdata[8*b +: 8];
                        m_mem[int'(m_pword)] = w;
                    end
                    m_busy = 0; m_serving = 0; m_pend = 0;
                end
            end else if (m_pend) begin
                m_serving = 1; m_busy = 1; m_left = LAT;
            end
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (m_valid && cmp_en) begin
            check("cyc_busy", {31'h0, o_busy}, {31'h0, m_busy});
            check("cyc_init_done", {31'h0, o_init_done}, {31'h0, m_done});
            check("cyc_data", o_data, m_data);
        end
    end

    // Issue one handshake from IDLE; returns the number of busy-high cycles.
    task automatic access(input logic r, input logic w, input logic [31:0] a,
                          input logic [31:0] d, input logic [3:0] c, output int hi);
        int n;
        rd = r; wr = w; addr = a; wdata = d; ctrl = c;
        n = 0;
        do begin @(negedge clk); n++; end while (!o_busy && n < 50);
        if (n >= 50) check("ack_timeout", 32'h0, 32'h1);
        rd = 0; wr = 0;
        hi = 0;
        while (o_busy && hi < 300) begin @(negedge clk); hi++; end
    endtask

    task automatic wait_init(output int n);
        n = 0;
        while (!o_init_done && n < 100) begin @(negedge clk); n++; end
    endtask

    initial begin
        int hi, n, t;
        rd = 0; wr = 0; addr = 0; wdata = 0; ctrl = 0; rst = 1;
        repeat (2) @(negedge clk);
        check("rst_busy", {31'h0, o_busy}, 32'h1);
        check("rst_init_done", {31'h0, o_init_done}, 32'h0);
        check("rst_data", o_data, 32'h0);
`ifndef MEM_REFRESH_STALL_EN
        cmp_en = 1;
        rst = 0;
        // Read issued during cycle 2 of the init stall.
        n = 0;
        repeat (2) begin @(negedge clk); n++; end
        rd = 1; addr = 32'h0;
        @(negedge clk); n++;
        rd = 0;
        while (!o_init_done && n < 100) begin @(negedge clk); n++; end
        check("init_len", n, INITC);
        check("init_gap_busy", {31'h0, o_busy}, 32'h0);
        @(negedge clk);
        check("init_rd_busy", {31'h0, o_busy}, 32'h1);
        hi = 0;
        while (o_busy && hi < 300) begin @(negedge clk); hi++; end
        check("init_rd_lat", hi, LAT);
        check("init_rd_data", o_data, 32'h0);

        access(0, 1, 32'h100, 32'hDEADBEEF, 4'hF, hi); check("wr_full_lat", hi, LAT);
        access(1, 0, 32'h100, 32'h0, 4'h0, hi);        check("rd_full_lat", hi, LAT);
        check("rd_full_data", o_data, 32'hDEADBEEF);

        access(0, 1, 32'h100, 32'h11223344, 4'b0101, hi);
        access(1, 0, 32'h100, 32'h0, 4'h0, hi);
        check("rd_masked_data", o_data, 32'hDE22BE44);

        access(1, 1, 32'h104, 32'h55, 4'hF, hi);
        check("rdwr_data", o_data, 32'h0);
        access(1, 0, 32'h100, 32'h0, 4'h0, hi);
        check("rd_back_100", o_data, 32'hDE22BE44);
        access(1, 0, 32'h104, 32'h0, 4'h0, hi);
        check("rdwr_no_write", o_data, 32'h0);

        access(0, 1, 32'h100, 32'hFFFFFFFF, 4'h0, hi); check("wr_nomask_lat", hi, LAT);
        access(1, 0, 32'h0001_0103, 32'h0, 4'h0, hi);
        check("alias_rd_data", o_data, 32'hDE22BE44);

        // Reset during cycle 2 of a write access.
        access(0, 1, 32'h108, 32'h12345678, 4'hF, hi);
        wr = 1; addr = 32'h108; wdata = 32'hAAAAAAAA; ctrl = 4'hF;
        n = 0;
        do begin @(negedge clk); n++; end while (!o_busy && n < 50);
        if (n >= 50) check("ack_timeout", 32'h0, 32'h1);
        wr = 0;
        @(negedge clk);
        rst = 1;
        @(negedge clk);
        check("midrst_busy", {31'h0, o_busy}, 32'h1);
        check("midrst_init_done", {31'h0, o_init_done}, 32'h0);
        check("midrst_data", o_data, 32'h0);
        rst = 0;
        wait_init(n);
        check("reinit_len", n, INITC);
        access(1, 0, 32'h108, 32'h0, 4'h0, hi);
        check("midrst_old_value", o_data, 32'h12345678);
`else
        rst = 0;
        wait_init(n);
        check("init_len", n, INITC);
        n = 0;
        while (!o_busy && n < 200) begin @(negedge clk); n++; end
        check("ref_seen", {31'h0, o_busy}, 32'h1);
        hi = 0;
        while (o_busy && hi < 300) begin @(negedge clk); hi++; end
        check("ref_width", hi, 6);
        n = 0;
        while (!o_busy && n < 200) begin @(negedge clk); n++; end
        check("ref_gap", n, 64 - 6);
        // Read issued in the middle of this refresh window.
        t = 1;
        repeat (2) begin @(negedge clk); t += int'(o_busy); end
        rd = 1; addr = 32'h0;
        @(negedge clk); t += int'(o_busy);
        rd = 0;
        n = 0;
        while (o_busy && n < 300) begin @(negedge clk); t += int'(o_busy); n++; end
        check("ref_rd_bound", {31'h0, (t <= 10)}, 32'h1);
        check("ref_rd_data", o_data, 32'h0);
`endif
        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
